// File: rtl/leak_rx_64_pkg.sv
// leak_rx_64_pkg
//   Shared constants and types for the leak-symbol key receiver.
//   KEY_W/SYM_W/NSYM : default frame geometry (64-bit key, 2-bit symbols, 32 symbols)
//   CNT_W            : symbol counter width, wide enough to hold NSYM without wrapping
//   NSLOT/SLOT_W     : key-store depth and index width
//   state_t          : receiver FSM encoding
package leak_rx_64_pkg;
  localparam int KEY_W  = 64;
  localparam int SYM_W  = 2;
  localparam int NSYM   = KEY_W / SYM_W;
  localparam int CNT_W  = $clog2(NSYM + 1);
  localparam int NSLOT  = 4;
  localparam int SLOT_W = 2;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;
endpackage

// File: rtl/leak_key_store.sv
// leak_key_store
//   Four-slot key store with per-slot valid bits.
//   clk, rst_all      : clock, synchronous active-high reset (clears valid bits only)
//   we, waddr, wdata  : registered write port
//   rd_idx            : read slot select
//   rd_key, rd_hit    : combinational read data / valid flag
//   A write is visible on the read port from the cycle after it is presented,
//   so a same-cycle read of the written slot returns the old contents.
module leak_key_store
  import leak_rx_64_pkg::*;
#(
  parameter int KEY_W = leak_rx_64_pkg::KEY_W
) (
  input  logic              clk,
  input  logic              rst_all,
  input  logic              we,
  input  logic [SLOT_W-1:0] waddr,
  input  logic [KEY_W-1:0]  wdata,
  input  logic [SLOT_W-1:0] rd_idx,
  output logic [KEY_W-1:0]  rd_key,
  output logic              rd_hit
);

  logic [NSLOT-1:0][KEY_W-1:0] mem;
  logic [NSLOT-1:0]            vld;

  always_ff @(posedge clk) begin
    if (rst_all)  vld        <= '0;
    else if (we)  vld[waddr] <= 1'b1;
  end

  // Data needs no reset: consumers qualify it with rd_hit.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rd_key = mem[rd_idx];
  assign rd_hit = vld[rd_idx];

endmodule

// File: rtl/leak_rx_64.sv
// leak_rx_64
//   Reassembles a KEY_W-bit key from NSYM leak symbols of SYM_W bits each,
//   LSB symbol first, and files completed keys into a 4-slot store by tag.
//   clk, rst_all        : clock, synchronous active-high reset
//   sym_valid, sym      : symbol stream; a gap mid-frame aborts the frame
//   sel_tag             : destination slot, sampled on the first symbol of a frame
//   key_out, key_tag    : last completed key and its tag
//   key_valid           : one-cycle pulse per completed frame
//   frame_err           : one-cycle pulse per aborted frame
//   busy                : high while collecting a frame
//   rd_idx, rd_key, rd_hit : combinational store read port
module leak_rx_64 #(
  parameter int KEY_W = leak_rx_64_pkg::KEY_W,
  parameter int SYM_W = leak_rx_64_pkg::SYM_W,
  parameter int NSYM  = KEY_W / SYM_W
) (
  input  logic             clk,
  input  logic             rst_all,
  input  logic             sym_valid,
  input  logic [SYM_W-1:0] sym,
  input  logic [1:0]       sel_tag,
  input  logic [1:0]       rd_idx,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic [1:0]       key_tag,
  output logic             frame_err,
  output logic             busy,
  output logic [KEY_W-1:0] rd_key,
  output logic             rd_hit
);
  import leak_rx_64_pkg::*;

  localparam int             CNT_W = $clog2(NSYM + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSYM - 1);

  state_t             state, state_nxt;
  logic [KEY_W-1:0]   shreg;
  logic [KEY_W-1:0]   shreg_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         tag_q;
  logic [1:0]         frame_tag;
  logic               last;

  // Every accepted symbol enters at the top and shifts right; after NSYM
  // symbols the first one has reached bits [SYM_W-1:0]. Stale bits below the
  // first symbol are shifted out before completion, so no clear is needed.
  assign shreg_nxt = {sym, shreg[KEY_W-1:SYM_W]};

  // cnt is 0 whenever the FSM is in IDLE, so one compare covers both states.
  assign last      = sym_valid && (cnt == LAST);
  assign frame_tag = (state == IDLE) ? sel_tag : tag_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst_all) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sym_valid && !last) state_nxt = COLLECT;
      COLLECT: if (!sym_valid || last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state == COLLECT);
  end

  // Frame datapath: counter, tag latch and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst_all) begin
      cnt       <= '0;
      tag_q     <= '0;
      key_out   <= '0;
      key_tag   <= '0;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      if (sym_valid) begin
        if (state == IDLE) tag_q <= sel_tag;
        if (last) begin
          cnt       <= '0;
          key_out   <= shreg_nxt;
          key_tag   <= frame_tag;
          key_valid <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else if (state == COLLECT) begin
        cnt       <= '0;
        frame_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sym_valid) shreg <= shreg_nxt;
  end

  // The store is written from the registered result during the key_valid
  // cycle, which gives the old-data read behaviour in that cycle.
  leak_key_store #(.KEY_W(KEY_W)) u_store (
    .clk    (clk),
    .rst_all(rst_all),
    .we     (key_valid),
    .waddr  (key_tag),
    .wdata  (key_out),
    .rd_idx (rd_idx),
    .rd_key (rd_key),
    .rd_hit (rd_hit)
  );

endmodule

// File: tb/tb_leak_rx_64.sv
module tb_leak_rx_64;
  logic        clk = 1'b0;
  logic        rst_all;
  logic        sym_valid;
  logic [1:0]  sym;
  logic [1:0]  sel_tag;
  logic [1:0]  rd_idx;
  logic [63:0] key_out;
  logic        key_valid;
  logic [1:0]  key_tag;
  logic        frame_err;
  logic        busy;
  logic [63:0] rd_key;
  logic        rd_hit;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int kv_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;

  leak_rx_64 dut (
    .clk      (clk),
    .rst_all  (rst_all),
    .sym_valid(sym_valid),
    .sym      (sym),
    .sel_tag  (sel_tag),
    .rd_idx   (rd_idx),
    .key_out  (key_out),
    .key_valid(key_valid),
    .key_tag  (key_tag),
    .frame_err(frame_err),
    .busy     (busy),
    .rd_key   (rd_key),
    .rd_hit   (rd_hit)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (key_valid) kv_cnt <= kv_cnt + 1;
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (key_valid && frame_err) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic chk1(input string name, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives n contiguous symbols of key (LSB symbol first). sel_tag carries the
  // real tag only on the first symbol so a late sample would be caught.
  // early is set if key_valid shows up before the 32nd symbol has been taken;
  // kv_cyc records the cycle in which key_valid appears after symbol 32.
  task automatic send_syms(input logic [63:0] key, input logic [1:0] tag, input int n,
                           output logic early, output int kv_cyc);
    early  = 1'b0;
    kv_cyc = -1;
    for (int i = 0; i < n; i++) begin
      sym_valid = 1'b1;
      sym       = key[2*i +: 2];
      sel_tag   = (i == 0) ? tag : ~tag;
      step();
      if (i == 0) chk1("busy_after_first_sym", busy, 1'b1);
      if (i < 31 && key_valid) early = 1'b1;
      if (i == 31 && key_valid) kv_cyc = cyc;
    end
  endtask

  task automatic full_frame(input logic [63:0] key, input logic [1:0] tag, output int kv_cyc);
    logic early;
    send_syms(key, tag, 32, early, kv_cyc);
    chk1("key_valid_early", early, 1'b0);
    chk1("key_valid_at_32", key_valid, 1'b1);
    chk1("frame_err_on_complete", frame_err, 1'b0);
    chk("key_out", key_out, key);
    chk("key_tag", 64'(key_tag), 64'(tag));
    chk1("busy_on_complete", busy, 1'b0);
  endtask

  initial begin
    logic early;
    int   t1, t2, kv0, fe0;

    rst_all   = 1'b1;
    sym_valid = 1'b0;
    sym       = 2'b00;
    sel_tag   = 2'b00;
    rd_idx    = 2'b00;

    // Reset
    repeat (3) step();
    chk("rst_key_out", key_out, 64'h0);
    chk1("rst_key_valid", key_valid, 1'b0);
    chk("rst_key_tag", 64'(key_tag), 64'h0);
    chk1("rst_frame_err", frame_err, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    for (int r = 0; r < 4; r++) begin
      rd_idx = 2'(r);
      #1;
      chk1("rst_rd_hit", rd_hit, 1'b0);
    end
    rst_all = 1'b0;
    step();

    // Good frame, tag 2; rd_idx held on 2 so the completion cycle sees the empty slot
    rd_idx = 2'd2;
    full_frame(64'h0123456789ABCDEF, 2'd2, t1);
    chk1("good_rd_hit_during_write", rd_hit, 1'b0);
    sym_valid = 1'b0;
    step();
    chk1("good_key_valid_one_cycle", key_valid, 1'b0);
    chk1("good_rd_hit_next", rd_hit, 1'b1);
    chk("good_rd_key_next", rd_key, 64'h0123456789ABCDEF);

    // Gap after 10 symbols, tag 2
    kv0 = kv_cnt;
    fe0 = fe_cnt;
    send_syms(64'h1122334455667788, 2'd2, 10, early, t2);
    sym_valid = 1'b0;
    step();
    chk1("gap_frame_err", frame_err, 1'b1);
    chk1("gap_key_valid", key_valid, 1'b0);
    chk1("gap_busy", busy, 1'b0);
    chk("gap_key_out_kept", key_out, 64'h0123456789ABCDEF);
    chk("gap_key_tag_kept", 64'(key_tag), 64'd2);
    chk("gap_slot2_kept", rd_key, 64'h0123456789ABCDEF);
    step();
    chk1("gap_frame_err_one_cycle", frame_err, 1'b0);
    chk("gap_kv_pulses", 64'(kv_cnt - kv0), 64'd0);
    chk("gap_fe_pulses", 64'(fe_cnt - fe0), 64'd1);

    // Back-to-back frames
    full_frame(64'hFFFF0000FFFF0000, 2'd0, t1);
    full_frame(64'h0000000000000001, 2'd3, t2);
    chk("b2b_spacing", 64'(t2 - t1), 64'd32);
    sym_valid = 1'b0;
    step();
    rd_idx = 2'd0; #1;
    chk1("b2b_slot0_hit", rd_hit, 1'b1);
    chk("b2b_slot0_key", rd_key, 64'hFFFF0000FFFF0000);
    rd_idx = 2'd3; #1;
    chk1("b2b_slot3_hit", rd_hit, 1'b1);
    chk("b2b_slot3_key", rd_key, 64'h0000000000000001);
    rd_idx = 2'd2; #1;
    chk("b2b_slot2_kept", rd_key, 64'h0123456789ABCDEF);

    // Reset at symbol 20, then a full frame
    kv0 = kv_cnt;
    fe0 = fe_cnt;
    send_syms(64'hDEADBEEFCAFEF00D, 2'd1, 20, early, t2);
    rst_all   = 1'b1;
    sym       = 2'b10;
    step();
    chk1("rmf_busy", busy, 1'b0);
    chk1("rmf_key_valid", key_valid, 1'b0);
    chk1("rmf_frame_err", frame_err, 1'b0);
    chk("rmf_key_out", key_out, 64'h0);
    rd_idx = 2'd2; #1;
    chk1("rmf_valid_cleared", rd_hit, 1'b0);
    rst_all   = 1'b0;
    sym_valid = 1'b0;
    step();
    chk1("rmf_no_frame_err", frame_err, 1'b0);
    full_frame(64'hA5A5A5A5A5A5A5A5, 2'd1, t1);
    sym_valid = 1'b0;
    step();
    chk("rmf_kv_pulses", 64'(kv_cnt - kv0), 64'd1);
    chk("rmf_fe_pulses", 64'(fe_cnt - fe0), 64'd0);

    // Read during write: overwrite slot 1 while reading it
    rd_idx = 2'd1;
    full_frame(64'h0F1E2D3C4B5A6978, 2'd1, t1);
    chk1("rdw_hit_old", rd_hit, 1'b1);
    chk("rdw_key_old", rd_key, 64'hA5A5A5A5A5A5A5A5);
    sym_valid = 1'b0;
    step();
    chk("rdw_key_new", rd_key, 64'h0F1E2D3C4B5A6978);

    chk("kv_fe_overlap", 64'(both_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
